// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//   Parametrised VGA raster generator. Produces the frame-buffer fetch address
//   for the current pixel and, RD_LAT pixel-enable cycles later, the matching
//   sync / data-enable / colour outputs, so returned pixel data lines up with
//   the timing it belongs to.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   en           pixel-rate enable; the raster advances only when en=1
//   q            pixel data {r,g,b} from the frame buffer
//   addr         {cur_y, cur_x} of the pixel being fetched (stage 0)
//   hs, vs, de   horizontal sync, vertical sync, active video (delayed)
//   r, g, b      colour outputs, forced to 0 outside active video
//   line_start   one-clk pulse after the horizontal counter wraps
//   frame_start  one-clk pulse after both counters wrap together
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int COLOR_W  = 3,
    parameter int COORD_W  = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3*COLOR_W-1:0]   q,
    output logic [2*COORD_W-1:0]   addr,
    output logic                   hs,
    output logic                   vs,
    output logic                   de,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   line_start,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
        $error("vga_timing_ctrl: RD_LAT must be in 1..4");
    end
    if (longint'(H_TOTAL) > (longint'(1) << COORD_W)) begin : g_chk_htotal
        $error("vga_timing_ctrl: H_TOTAL does not fit in COORD_W");
    end
    if (longint'(V_TOTAL) > (longint'(1) << COORD_W)) begin : g_chk_vtotal
        $error("vga_timing_ctrl: V_TOTAL does not fit in COORD_W");
    end

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // Region boundaries carry one extra bit: a sync pulse ending exactly at
    // the total would otherwise truncate to 0 when the total is 2^COORD_W.
    localparam logic [COORD_W:0] H_ACT_END  = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] H_SYNC_BEG = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0] H_SYNC_END = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0] V_ACT_END  = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0] V_SYNC_BEG = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0] V_SYNC_END = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COORD_W:0]   x_ext;
    logic [COORD_W:0]   y_ext;
    logic               x_wrap;
    logic               y_wrap;
    logic               hs0;
    logic               vs0;
    logic               de0;

    logic [RD_LAT-1:0]  hs_pipe;
    logic [RD_LAT-1:0]  vs_pipe;
    logic [RD_LAT-1:0]  de_pipe;

    assign x_ext  = {1'b0, cur_x};
    assign y_ext  = {1'b0, cur_y};
    assign x_wrap = (cur_x == H_LAST);
    assign y_wrap = (cur_y == V_LAST);

    // Stage-0 timing terms for the pixel currently being fetched.
    assign hs0 = (x_ext >= H_SYNC_BEG && x_ext < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign vs0 = (y_ext >= V_SYNC_BEG && y_ext < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign de0 = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);

    assign addr = {cur_y, cur_x};

    // Raster counters and line/frame strobes.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let cur_y see the new cur_x.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x       <= '0;
            cur_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes are recomputed every clk so they never stretch across
            // idle (en=0) cycles.
            line_start  <= en && x_wrap;
            frame_start <= en && x_wrap && y_wrap;
            if (en) begin
                cur_x <= x_wrap ? '0 : cur_x + 1'b1;
                if (x_wrap) begin
                    cur_y <= y_wrap ? '0 : cur_y + 1'b1;
                end
            end
        end
    end

    // Delay line matching the frame-buffer read latency.
    // NOTE: unlike a data memory, this shift register is reset: its last stage
    // drives the sync pins, which must sit at their inactive level out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe <= {RD_LAT{~SYNC_POL}};
            vs_pipe <= {RD_LAT{~SYNC_POL}};
            de_pipe <= '0;
        end else if (en) begin
            hs_pipe[0] <= hs0;
            vs_pipe[0] <= vs0;
            de_pipe[0] <= de0;
            for (int i = 1; i < RD_LAT; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
        end
    end

    assign hs = hs_pipe[RD_LAT-1];
    assign vs = vs_pipe[RD_LAT-1];
    assign de = de_pipe[RD_LAT-1];

    // Colour gating: blank outside active video.
    // NOTE: every output gets a default before the if, so no latch is inferred.
    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        if (de) begin
            r = q[3*COLOR_W-1:2*COLOR_W];
            g = q[2*COLOR_W-1:COLOR_W];
            b = q[COLOR_W-1:0];
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Two instances: default 640x480 timing (unit 0) and a tiny 8x6 raster with
//   active-high sync and RD_LAT=3 (unit 1). Each cycle both are compared with a
//   reference model that tracks only "pixels advanced since reset" and derives
//   every output from that count arithmetically.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    // Reference configuration per unit: 0 = defaults, 1 = tiny raster.
    localparam int HA [2] = '{640, 4};
    localparam int HFP[2] = '{16, 1};
    localparam int HSW[2] = '{96, 1};
    localparam int HT [2] = '{800, 8};
    localparam int VA [2] = '{480, 3};
    localparam int VFP[2] = '{10, 1};
    localparam int VSW[2] = '{2, 1};
    localparam int VT [2] = '{525, 6};
    localparam int LAT[2] = '{1, 3};
    localparam int POL[2] = '{0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, en_d, rst_s, en_s;
    logic [8:0]  q_d, q_s;
    logic [31:0] addr_d, addr_s;
    logic        hs_d, vs_d, de_d, ls_d, fs_d;
    logic        hs_s, vs_s, de_s, ls_s, fs_s;
    logic [2:0]  r_d, g_d, b_d, r_s, g_s, b_s;

    vga_timing_ctrl dut_d (
        .clk(clk), .rst(rst_d), .en(en_d), .q(q_d), .addr(addr_d),
        .hs(hs_d), .vs(vs_d), .de(de_d), .r(r_d), .g(g_d), .b(b_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .RD_LAT(3)
    ) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .q(q_s), .addr(addr_s),
        .hs(hs_s), .vs(vs_s), .de(de_s), .r(r_s), .g(g_s), .b(b_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    int checks   = 0;
    int failures = 0;

    longint pos  [2];
    bit     ls_m [2];
    bit     fs_m [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int u, input longint p);
        longint x, y;
        x = p % HT[u];
        y = (p / HT[u]) % VT[u];
        return {16'(y), 16'(x)};
    endfunction

    // {hs, vs, de} as seen at the output: the pixel from LAT en-cycles ago.
    function automatic logic [2:0] exp_dly(input int u, input longint p);
        longint pd, x, y;
        logic pol, hs, vs, de;
        pol = (POL[u] != 0);
        if (p < LAT[u]) return {~pol, ~pol, 1'b0};
        pd = p - LAT[u];
        x  = pd % HT[u];
        y  = (pd / HT[u]) % VT[u];
        hs = (x >= HA[u] + HFP[u] && x < HA[u] + HFP[u] + HSW[u]) ? pol : ~pol;
        vs = (y >= VA[u] + VFP[u] && y < VA[u] + VFP[u] + VSW[u]) ? pol : ~pol;
        de = (x < HA[u]) && (y < VA[u]);
        return {hs, vs, de};
    endfunction

    task automatic model_edge(input int u, input logic r, input logic e);
        if (r) begin
            pos[u] = 0; ls_m[u] = 0; fs_m[u] = 0;
        end else if (e) begin
            ls_m[u] = (pos[u] % HT[u] == HT[u] - 1);
            fs_m[u] = ls_m[u] && ((pos[u] / HT[u]) % VT[u] == VT[u] - 1);
            pos[u]++;
        end else begin
            ls_m[u] = 0; fs_m[u] = 0;
        end
    endtask

    task automatic compare_all();
        logic [2:0] e;
        e = exp_dly(0, pos[0]);
        check("d_addr", 64'(addr_d), 64'(exp_addr(0, pos[0])));
        check("d_hs", 64'(hs_d), 64'(e[2]));
        check("d_vs", 64'(vs_d), 64'(e[1]));
        check("d_de", 64'(de_d), 64'(e[0]));
        check("d_rgb", 64'({r_d, g_d, b_d}), 64'(e[0] ? q_d : 9'd0));
        check("d_line_start", 64'(ls_d), 64'(ls_m[0]));
        check("d_frame_start", 64'(fs_d), 64'(fs_m[0]));
        e = exp_dly(1, pos[1]);
        check("s_addr", 64'(addr_s), 64'(exp_addr(1, pos[1])));
        check("s_hs", 64'(hs_s), 64'(e[2]));
        check("s_vs", 64'(vs_s), 64'(e[1]));
        check("s_de", 64'(de_s), 64'(e[0]));
        check("s_rgb", 64'({r_s, g_s, b_s}), 64'(e[0] ? q_s : 9'd0));
        check("s_line_start", 64'(ls_s), 64'(ls_m[1]));
        check("s_frame_start", 64'(fs_s), 64'(fs_m[1]));
    endtask

    // Inputs are stable here; the model consumes them, then the edge happens.
    task automatic step();
        model_edge(0, rst_d, en_d);
        model_edge(1, rst_s, en_s);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int first_hs, hs_cnt, de_cnt, ls_cnt, ls1, ls2, fs1, fs2, wide, prev_ls, n;

        pos = '{0, 0}; ls_m = '{0, 0}; fs_m = '{0, 0};
        rst_d = 1; en_d = 0; q_d = 9'h1C7;
        rst_s = 1; en_s = 0; q_s = 9'h0;
        step();
        step();

        // A: defaults, en=1, q=1C7 held.
        rst_d = 0; en_d = 1;
        first_hs = -1; hs_cnt = 0; de_cnt = 0; ls1 = -1; ls2 = -1;
        for (int c = 1; c <= 1700; c++) begin
            step();
            if (!hs_d && first_hs < 0) first_hs = c;
            if (c <= 800 && !hs_d) hs_cnt++;
            if (c <= 800 && de_d) begin
                de_cnt++;
                check("A_rgb_active", 64'({r_d, g_d, b_d}), 64'({3'd7, 3'd0, 3'd7}));
            end
            if (ls_d) begin
                if (ls1 < 0) ls1 = c; else if (ls2 < 0) ls2 = c;
            end
        end
        check("A_first_hs_fall", 64'(first_hs), 64'(657));
        check("A_hs_low_clks", 64'(hs_cnt), 64'(96));
        check("A_de_clks_line", 64'(de_cnt), 64'(640));
        check("A_first_line_start", 64'(ls1), 64'(800));
        check("A_line_period", 64'(ls2 - ls1), 64'(800));

        // B: defaults, en toggling 1/0 each clk.
        rst_d = 1; step(); rst_d = 0;
        hs_cnt = 0; ls1 = -1; ls2 = -1; wide = 0; prev_ls = 0;
        for (int c = 1; c <= 3300; c++) begin
            en_d = (c % 2 == 1);
            step();
            if (c <= 1600 && !hs_d) hs_cnt++;
            if (ls_d && prev_ls != 0) wide++;
            prev_ls = int'(ls_d);
            if (ls_d) begin
                if (ls1 < 0) ls1 = c; else if (ls2 < 0) ls2 = c;
            end
        end
        check("B_hs_low_clks", 64'(hs_cnt), 64'(192));
        check("B_line_period", 64'(ls2 - ls1), 64'(1600));
        check("B_ls_width", 64'(wide), 64'(0));

        // C: reset mid-line, then line_start 800 clks after release.
        rst_d = 1; en_d = 1; step(); rst_d = 0;
        for (int c = 1; c <= 300; c++) step();
        check("C_addr_before", 64'(addr_d), 64'({16'd0, 16'd300}));
        rst_d = 1; step();
        check("C_addr_rst", 64'(addr_d), 64'(0));
        check("C_hs_vs_rst", 64'({hs_d, vs_d}), 64'(2'b11));
        check("C_de_rgb_rst", 64'({de_d, r_d, g_d, b_d}), 64'(0));
        rst_d = 0; n = 0;
        while (!ls_d && n < 2000) begin
            step(); n++;
        end
        check("C_ls_after_release", 64'(n), 64'(800));

        // D: tiny raster, SYNC_POL=1, RD_LAT=3, en=1.
        rst_s = 1; step(); rst_s = 0; en_s = 1;
        first_hs = -1; hs_cnt = 0; de_cnt = 0; ls_cnt = 0; fs1 = -1; fs2 = -1;
        for (int c = 1; c <= 100; c++) begin
            q_s = 9'($urandom);
            step();
            if (hs_s && first_hs < 0) first_hs = c;
            if (c <= 48) begin
                if (hs_s) hs_cnt++;
                if (de_s) de_cnt++;
                if (ls_s) ls_cnt++;
            end
            if (fs_s) begin
                check("D_fs_with_ls", 64'(ls_s), 64'(1));
                if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
            end
        end
        check("D_first_hs_high", 64'(first_hs), 64'(8));
        check("D_hs_high_per_frame", 64'(hs_cnt), 64'(6));
        check("D_de_per_frame", 64'(de_cnt), 64'(12));
        check("D_ls_per_frame", 64'(ls_cnt), 64'(6));
        check("D_first_frame_start", 64'(fs1), 64'(48));
        check("D_frame_period", 64'(fs2 - fs1), 64'(48));

        // E: random enable, data and occasional reset on both units.
        for (int c = 0; c < 20000; c++) begin
            en_d  = ($urandom % 4) != 0;
            en_s  = ($urandom % 4) != 0;
            rst_d = ($urandom % 800) == 0;
            rst_s = ($urandom % 300) == 0;
            q_d   = 9'($urandom);
            q_s   = 9'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
